pokey_timer_pair: RTL
=====================

Name: pokey_timer_pair

Overview:
- Paired audio-frequency divider: the terminal-count end of the POKEY counter chain.
- Consumes base-clock ticks and AUDF register writes; produces one-cycle borrow (underflow) pulses for the poly/distortion and output stages.
- Two 8-bit down-counters (channel pair 1/2 or 3/4), independent or joined into one 16-bit counter.
- One instance per channel pair.

Parameters:
- WIDTH, 8, width of each channel's AUDF register and counter; joined width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- tick_lo  input  1  base-clock enable for low channel, one clk wide
- tick_hi  input  1  base-clock enable for high channel; ignored when join=1
- join  input  1  1 = 16-bit mode (low channel borrow clocks high channel)
- wr_lo  input  1  write din to audf_lo this cycle
- wr_hi  input  1  write din to audf_hi this cycle
- din  input  WIDTH  AUDF write data
- stimer  input  1  restart: load both counters from AUDF
- borrow_lo  output  1  one-cycle underflow pulse, low channel
- borrow_hi  output  1  one-cycle underflow pulse, high channel / 16-bit counter
- cnt_lo  output  WIDTH  current low counter value (debug/verification)
- cnt_hi  output  WIDTH  current high counter value

Behaviour:
- Reset (async, any time, including mid-count):
  - audf_lo, audf_hi, cnt_lo, cnt_hi = 0.
  - borrow_lo, borrow_hi = 0.
  - Reset wins over every other input.
- Priority per cycle: reset > stimer > tick-driven count. AUDF writes are independent of count activity.
- AUDF write: register updates at the edge. A reload in the same cycle uses the pre-write AUDF value. stimer in the same cycle loads din, i.e. the post-write value.
- stimer:
  - cnt_lo <= audf_lo, cnt_hi <= audf_hi.
  - No borrow pulse.
  - Coincident ticks are discarded.
- 8-bit mode (join=0), each channel independent, on its own tick:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: cnt <= audf and borrow asserted for exactly the next clk cycle (registered, 1-cycle latency from the tick).
  - Period = audf+1 ticks. audf=0 gives a borrow on every tick.
- 16-bit mode (join=1), on tick_lo only:
  - cnt_lo != 0: cnt_lo-1; hi unchanged.
  - cnt_lo == 0 and cnt_hi != 0: cnt_lo <= all-ones, cnt_hi <= cnt_hi-1, borrow_lo pulse.
  - Both == 0: cnt_lo <= audf_lo, cnt_hi <= audf_hi, borrow_lo and borrow_hi pulse in the same cycle.
  - Period of borrow_hi = {audf_hi,audf_lo}+1 ticks.
- Borrow outputs:
  - Registered, never wider than one clk.
  - Back-to-back ticks with audf=0 give continuous high, one pulse per tick.
  - Deassert on a cycle with no underflow.
- Changing join mid-count: counters keep their values; the new mode applies from the next tick. No reload, no borrow.
- tick_lo and tick_hi together with join=0: both channels step independently in that cycle.

Test Plan:
- Reset release, join=0, wr_lo with din=3, stimer, then tick_lo every cycle -> cnt_lo 3,2,1,0,3…; borrow_lo high 1 cycle after each 0→3 reload; period 4 ticks.
- audf_lo=0, tick_lo continuous -> borrow_lo high every cycle; cnt_lo stays 0.
- join=1, audf_hi=0x01, audf_lo=0x02, stimer, tick_lo continuous:
  - borrow_lo at lo wrap after 3 ticks (cnt_lo→0xFF, cnt_hi→0).
  - borrow_hi + borrow_lo after 259 ticks total.
  - Repeats every 259 ticks.
  - tick_hi toggling has no effect.
- wr_lo din=5 in the same cycle as a reload from old audf_lo=2 -> counter loads 2; next reload loads 5. wr_lo din=7 with stimer same cycle -> cnt_lo=7.
- Assert reset mid-count (cnt_lo=0x40, borrow pending) asynchronously between edges -> all counters, AUDF and borrows read 0 immediately; no borrow emitted after release.
- Flip join 0→1 with cnt_lo=2, cnt_hi=9 -> values held; subsequent tick_lo gives 1, 0, then 0xFF with cnt_hi=8 and borrow_lo pulse; no borrow_hi.

Source files
------------

// File: rtl/pokey_timer_pair.sv
// Paired AUDF divider: two WIDTH-bit down-counters, independent or chained to 2*WIDTH; borrows are registered, 1 clk after the tick.
// No backpressure: every tick, write and stimer is consumed in the cycle it is presented.
module pokey_timer_pair #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_lo,
  input  logic             tick_hi,
  input  logic             join_mode,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [WIDTH-1:0] din,
  input  logic             stimer,
  output logic             borrow_lo,
  output logic             borrow_hi,
  output logic [WIDTH-1:0] cnt_lo,
  output logic [WIDTH-1:0] cnt_hi
);

  logic [WIDTH-1:0] audf_lo, audf_hi;
  logic [WIDTH-1:0] audf_lo_new, audf_hi_new;
  logic [WIDTH-1:0] nxt_lo, nxt_hi;
  logic             uf_lo, uf_hi;

  // stimer sees the value being written this cycle; tick reloads see the old one
  assign audf_lo_new = wr_lo ? din : audf_lo;
  assign audf_hi_new = wr_hi ? din : audf_hi;

  always_comb begin
    nxt_lo = cnt_lo;
    nxt_hi = cnt_hi;
    uf_lo  = 1'b0;
    uf_hi  = 1'b0;
    if (stimer) begin
      nxt_lo = audf_lo_new;
      nxt_hi = audf_hi_new;
    end else if (join_mode) begin
      if (tick_lo) begin
        if (cnt_lo != '0) begin
          nxt_lo = cnt_lo - WIDTH'(1);
        end else if (cnt_hi != '0) begin
          nxt_lo = '1;
          nxt_hi = cnt_hi - WIDTH'(1);
          uf_lo  = 1'b1;
        end else begin
          nxt_lo = audf_lo;
          nxt_hi = audf_hi;
          uf_lo  = 1'b1;
          uf_hi  = 1'b1;
        end
      end
    end else begin
      if (tick_lo) begin
        if (cnt_lo != '0) begin
          nxt_lo = cnt_lo - WIDTH'(1);
        end else begin
          nxt_lo = audf_lo;
          uf_lo  = 1'b1;
        end
      end
      if (tick_hi) begin
        if (cnt_hi != '0) begin
          nxt_hi = cnt_hi - WIDTH'(1);
        end else begin
          nxt_hi = audf_hi;
          uf_hi  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audf_lo   <= '0;
      audf_hi   <= '0;
      cnt_lo    <= '0;
      cnt_hi    <= '0;
      borrow_lo <= 1'b0;
      borrow_hi <= 1'b0;
    end else begin
      if (wr_lo) audf_lo <= din;
      if (wr_hi) audf_hi <= din;
      cnt_lo    <= nxt_lo;
      cnt_hi    <= nxt_hi;
      borrow_lo <= uf_lo;
      borrow_hi <= uf_hi;
    end
  end

endmodule
